core_ctrl_fsm: RTL and testbench

Multi-cycle sequencing controller for the npc core. It drives the instruction-fetch handshake, latches each fetched word into the instruction register that feeds the decoder, and classifies the decoded opcode/func3. It then issues load/store requests to the LSU and produces the one-cycle register-file and PC write strobes that retire each instruction. It also halts on `ebreak`/`ecall`, flags illegal opcodes and bus timeouts, and keeps a retired-instruction counter.

---
 rtl/core_ctrl_fsm_pkg.sv | 42 ++++
 rtl/ctrl_timeout.sv | 37 +++
 rtl/core_ctrl_fsm.sv | 148 ++++++++++++++
 tb/tb_core_ctrl_fsm.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_fsm_pkg.sv
// Shared definitions for the npc core sequencing controller: RV32 major opcodes,
// controller state encoding and the instruction class latched at decode.
package core_ctrl_fsm_pkg;

  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcSystem = 7'b1110011;

  // func3 of ecall/ebreak; every other SYSTEM func3 is a CSR access.
  localparam logic [2:0] Func3Priv = 3'b000;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StWaitI,
    StDecode,
    StExec,
    StMem,
    StWaitM,
    StHalt,
    StFault
  } ctrl_state_e;

  typedef enum logic [1:0] {
    ClsAlu,
    ClsBranch,
    ClsLoad,
    ClsStore
  } inst_class_e;

  function automatic logic is_mem_class(inst_class_e cls);
    return (cls == ClsLoad) || (cls == ClsStore);
  endfunction

endpackage

// File: rtl/ctrl_timeout.sv
// 16-bit wait counter for the fetch/LSU response windows. hit_o flags the
// Limit-th consecutive waiting cycle; the caller decides whether a response wins.
module ctrl_timeout #(
  parameter int unsigned Limit = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam logic [15:0] LastCount = 16'(Limit - 1);

  logic [15:0] count_q, count_d;

  // count_q is the number of waiting cycles already completed in this window.
  assign hit_o = (count_q == LastCount);

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle sequencing controller: fetch handshake, decode classification,
// LSU requests, retire strobes, halt/fault flags and retired-instruction count.
module core_ctrl_fsm
  import core_ctrl_fsm_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  input  logic        ifu_rsp_valid,
  output logic        inst_we,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  output logic        lsu_req_valid,
  output logic        lsu_req_wen,
  input  logic        lsu_req_ready,
  input  logic        lsu_rsp_valid,
  output logic        rf_we,
  output logic        pc_we,
  output logic        halt,
  output logic        fault,
  output logic [31:0] retired
);

  ctrl_state_e state_q, state_d;
  inst_class_e cls_q, cls_d;
  logic        halt_q, fault_q;
  logic [31:0] retired_q;
  logic        tmo_clr, tmo_en, tmo_hit;

  ctrl_timeout #(
    .Limit (TIMEOUT)
  ) u_timeout (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (tmo_clr),
    .en_i   (tmo_en),
    .hit_o  (tmo_hit)
  );

  always_comb begin
    state_d       = state_q;
    cls_d         = cls_q;
    ifu_req_valid = 1'b0;
    inst_we       = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_req_wen   = 1'b0;
    rf_we         = 1'b0;
    pc_we         = 1'b0;
    tmo_clr       = 1'b0;
    tmo_en        = 1'b0;

    unique case (state_q)
      StIdle: state_d = StFetch;

      StFetch: begin
        ifu_req_valid = 1'b1;
        if (ifu_req_ready) begin
          state_d = StWaitI;
          tmo_clr = 1'b1;
        end
      end

      StWaitI: begin
        inst_we = ifu_rsp_valid;
        if (ifu_rsp_valid) begin
          state_d = StDecode;
        end else begin
          tmo_en = 1'b1;
          if (tmo_hit) state_d = StFault;
        end
      end

      StDecode: begin
        state_d = StExec;
        case (opcode)
          OpcLoad:   cls_d = ClsLoad;
          OpcStore:  cls_d = ClsStore;
          OpcBranch: cls_d = ClsBranch;
          OpcOp, OpcOpImm, OpcLui, OpcAuipc, OpcJal, OpcJalr: cls_d = ClsAlu;
          OpcSystem: state_d = (func3 == Func3Priv) ? StHalt : StFault;
          default:   state_d = StFault;
        endcase
      end

      StExec: begin
        if (is_mem_class(cls_q)) begin
          state_d = StMem;
        end else begin
          pc_we   = 1'b1;
          rf_we   = (cls_q != ClsBranch);
          state_d = StFetch;
        end
      end

      // cls_q is frozen until the next decode, so wen is stable while valid.
      StMem: begin
        lsu_req_valid = 1'b1;
        lsu_req_wen   = (cls_q == ClsStore);
        if (lsu_req_ready) begin
          state_d = StWaitM;
          tmo_clr = 1'b1;
        end
      end

      StWaitM: begin
        if (lsu_rsp_valid) begin
          pc_we   = 1'b1;
          rf_we   = (cls_q == ClsLoad);
          state_d = StFetch;
        end else begin
          tmo_en = 1'b1;
          if (tmo_hit) state_d = StFault;
        end
      end

      StHalt:  state_d = StHalt;
      StFault: state_d = StFault;

      default: state_d = StFault;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cls_q     <= ClsAlu;
      halt_q    <= 1'b0;
      fault_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      halt_q  <= halt_q | (state_d == StHalt);
      fault_q <= fault_q | (state_d == StFault);
      if (pc_we) begin
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  assign halt    = halt_q;
  assign fault   = fault_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Directed bench for core_ctrl_fsm: stimulus pushes expected retire/LSU events,
// a negedge monitor pops and compares them when the DUT strobes.
module tb_core_ctrl_fsm;
  import core_ctrl_fsm_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifu_req_ready = 1'b0, ifu_rsp_valid = 1'b0;
  logic        lsu_req_ready = 1'b0, lsu_rsp_valid = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  func3 = 3'd0;

  logic        ifu_req_valid, inst_we, lsu_req_valid, lsu_req_wen, rf_we, pc_we, halt, fault;
  logic [31:0] retired;
  logic        b_ifu_req_valid, b_inst_we, b_lsu_req_valid, b_lsu_req_wen, b_rf_we, b_pc_we;
  logic        b_halt, b_fault;
  logic [31:0] b_retired;

  always #5 clk = ~clk;

  core_ctrl_fsm dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .inst_we(inst_we),
    .opcode(opcode), .func3(func3),
    .lsu_req_valid(lsu_req_valid), .lsu_req_wen(lsu_req_wen),
    .lsu_req_ready(lsu_req_ready), .lsu_rsp_valid(lsu_rsp_valid),
    .rf_we(rf_we), .pc_we(pc_we), .halt(halt), .fault(fault), .retired(retired)
  );

  // Same stimulus, short timeout window.
  core_ctrl_fsm #(.TIMEOUT(4)) dut_t4 (
    .clk(clk), .rst(rst),
    .ifu_req_valid(b_ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .inst_we(b_inst_we),
    .opcode(opcode), .func3(func3),
    .lsu_req_valid(b_lsu_req_valid), .lsu_req_wen(b_lsu_req_wen),
    .lsu_req_ready(lsu_req_ready), .lsu_rsp_valid(lsu_rsp_valid),
    .rf_we(b_rf_we), .pc_we(b_pc_we), .halt(b_halt), .fault(b_fault), .retired(b_retired)
  );

  typedef struct { logic rf; logic [31:0] ret; int lat; } ret_t;
  typedef struct { logic wen; int hold; } lsu_t;

  ret_t        exp_ret[$];
  lsu_t        exp_lsu[$];
  int          n_vec = 0;
  int          n_fail = 0;
  logic [31:0] exp_retired = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: sample mid-cycle, pop expectations on LSU handshakes and retirements.
  int cyc = 0, fstart = 0, lsu_hold = 0;
  bit fetching = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      fetching = 1'b0;
      lsu_hold = 0;
    end else begin
      cyc++;
      if (ifu_req_valid && !fetching) begin
        fetching = 1'b1;
        fstart   = cyc;
      end
      if (lsu_req_valid) lsu_hold++;
      if (lsu_req_valid && lsu_req_ready) begin
        if (exp_lsu.size() == 0) begin
          chk("lsu_unexpected_req", 32'd1, 32'd0);
        end else begin
          lsu_t l;
          l = exp_lsu.pop_front();
          chk("lsu_req_wen", lsu_req_wen, l.wen);
          chk("lsu_req_hold", lsu_hold, l.hold);
        end
        lsu_hold = 0;
      end
      if (rf_we) chk("rf_we_without_pc_we", pc_we, 1'b1);
      if (pc_we) begin
        if (exp_ret.size() == 0) begin
          chk("unexpected_retire", 32'd1, 32'd0);
        end else begin
          ret_t r;
          r = exp_ret.pop_front();
          chk("retire_rf_we", rf_we, r.rf);
          chk("retire_count", retired, r.ret);
          if (r.lat != 0) chk("retire_latency", cyc - fstart + 1, r.lat);
        end
        fetching = 1'b0;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fetch;
    for (int i = 0; i < 20 && !ifu_req_valid; i++) tick();
    if (!ifu_req_valid) begin
      n_vec++;
      n_fail++;
      $display("FAIL fetch_req: ifu_req_valid got 0, expected 1 within 20 cycles");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $fatal(1, "no fetch request, stopping");
    end
  endtask

  // Leaves the DUT in its DECODE cycle.
  task automatic do_fetch(input int rsp_wait);
    wait_fetch();
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0;
    repeat (rsp_wait) tick();
    ifu_rsp_valid = 1'b1;
    #1;
    chk("inst_we_on_rsp", inst_we, 1'b1);
    tick();
    ifu_rsp_valid = 1'b0;
  endtask

  task automatic run_instr(input logic [6:0] opc, input int rsp_wait, input int rdy_wait,
                           input int mrsp_wait, input int lat);
    bit   mem;
    ret_t r;
    lsu_t l;
    mem    = (opc == OpcLoad) || (opc == OpcStore);
    opcode = opc;
    func3  = 3'b000;
    r.rf   = (opc != OpcBranch) && (opc != OpcStore);
    r.ret  = exp_retired;
    r.lat  = lat;
    exp_ret.push_back(r);
    exp_retired++;
    if (mem) begin
      l.wen  = (opc == OpcStore);
      l.hold = rdy_wait + 1;
      exp_lsu.push_back(l);
    end
    do_fetch(rsp_wait);
    tick();  // EXEC
    if (mem) begin
      tick();  // MEM
      repeat (rdy_wait) tick();
      lsu_req_ready = 1'b1;
      tick();
      lsu_req_ready = 1'b0;
      repeat (mrsp_wait) tick();
      lsu_rsp_valid = 1'b1;
      tick();
      lsu_rsp_valid = 1'b0;
    end else begin
      tick();
    end
  endtask

  // Returns in the IDLE cycle after release.
  task automatic do_reset;
    rst = 1'b0;
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0;
    lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    exp_retired = 32'd0;
  endtask

  initial begin
    logic req_seen;
    lsu_t l;

    #1;
    chk("reset_flags", {ifu_req_valid, inst_we, lsu_req_valid, lsu_req_wen, rf_we, pc_we,
                        halt, fault}, 8'h00);
    chk("reset_retired", retired, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    chk("idle_no_req", ifu_req_valid, 1'b0);

    run_instr(OpcOpImm, 0, 0, 0, 4);   // ADDI zero-wait
    run_instr(OpcBranch, 0, 0, 0, 4);  // BEQ
    run_instr(OpcStore, 0, 3, 0, 9);   // ready after 3 cycles
    run_instr(OpcLoad, 0, 0, 10, 16);  // response after 10 cycles
    chk("retired_after_load", retired, exp_retired);
    run_instr(OpcLui, 2, 0, 0, 6);
    run_instr(OpcJal, 0, 0, 0, 4);
    run_instr(OpcLoad, 0, 0, 0, 6);

    // Reset while waiting on a load response.
    opcode = OpcLoad;
    l.wen  = 1'b0;
    l.hold = 1;
    exp_lsu.push_back(l);
    do_fetch(0);
    tick();
    tick();
    lsu_req_ready = 1'b1;
    tick();
    lsu_req_ready = 1'b0;
    tick();
    chk("retired_before_reset", retired, exp_retired);
    #2 rst = 1'b0;
    #1;
    chk("midreset_flags", {ifu_req_valid, inst_we, lsu_req_valid, lsu_req_wen, rf_we, pc_we,
                           halt, fault}, 8'h00);
    chk("midreset_retired", retired, 32'd0);
    tick();
    rst = 1'b1;
    exp_retired = 32'd0;
    run_instr(OpcOpImm, 0, 0, 0, 4);

    // Fetch response never arrives: TIMEOUT=4 instance faults after 4 waiting cycles.
    do_reset();
    opcode = OpcOpImm;
    wait_fetch();
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0;
    repeat (3) tick();
    chk("t4_no_fault_at_4th_wait", b_fault, 1'b0);
    tick();
    chk("t4_fault_outputs", {b_ifu_req_valid, b_inst_we, b_lsu_req_valid, b_lsu_req_wen,
                             b_rf_we, b_pc_we, b_halt, b_fault}, 8'h01);
    chk("t255_no_fault", fault, 1'b0);

    // Response on the 4th waiting cycle wins over the limit.
    do_reset();
    run_instr(OpcOpImm, 3, 0, 0, 7);
    chk("t4_rsp_wins_fault", b_fault, 1'b0);
    chk("t4_rsp_wins_retired", b_retired, 32'd1);

    // ecall/ebreak halts and stops fetching.
    do_reset();
    opcode = OpcSystem;
    func3  = 3'b000;
    do_fetch(0);
    tick();
    chk("halt_set", halt, 1'b1);
    chk("halt_no_fault", fault, 1'b0);
    req_seen = 1'b0;
    repeat (4) begin
      tick();
      req_seen |= ifu_req_valid;
    end
    chk("halt_no_fetch", req_seen, 1'b0);
    chk("halt_sticky", halt, 1'b1);

    // Illegal opcode.
    do_reset();
    opcode = 7'b0000000;
    do_fetch(0);
    tick();
    chk("illegal_fault", fault, 1'b1);
    chk("illegal_no_halt", halt, 1'b0);

    // CSR access (SYSTEM, func3 != 0) is unimplemented.
    do_reset();
    opcode = OpcSystem;
    func3  = 3'b010;
    do_fetch(0);
    tick();
    chk("csr_fault", fault, 1'b1);
    chk("csr_no_halt", halt, 1'b0);

    chk("retire_queue_drained", exp_ret.size(), 32'd0);
    chk("lsu_queue_drained", exp_lsu.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
